// File: rtl/lcd_pkg.sv
// lcd_pkg: shared command bytes, init list length and sequencer state encoding
//   CMD_*      HD44780 command bytes sent by the sequencer
//   INIT_LEN   number of bytes in the power-up command list
//   state_t    sequencer FSM states
//   init_byte  maps an init-list position to its command byte
package lcd_pkg;
    localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_ENTRY     = 8'h06;
    localparam logic [7:0] CMD_LINE1     = 8'h80;
    localparam logic [7:0] CMD_LINE2     = 8'hC0;
    localparam int INIT_LEN = 7;
    typedef enum logic [3:0] {
        S_PWRUP,
        S_INIT_ISSUE,
        S_INIT_WAIT,
        S_CLR_WAIT,
        S_IDLE,
        S_ADDR_ISSUE,
        S_ADDR_WAIT,
        S_FETCH,
        S_FETCH2,
        S_CHAR_ISSUE,
        S_CHAR_WAIT
    } state_t;
    // 0x38 is sent four times before display-on, clear and entry mode
    function automatic logic [7:0] init_byte(input logic [2:0] i);
        return i < 3'd4 ? CMD_FUNC_8B2L : i == 3'd4 ? CMD_DISP_ON : i == 3'd5 ? CMD_CLEAR : CMD_ENTRY;
    endfunction
endpackage

// File: rtl/lcd_delay_counter.sv
// lcd_delay_counter: loadable down-counter used for the power-up and clear-display waits
//   i_clk    clock
//   i_rst_n  synchronous active-low reset, reloads RST_VAL
//   i_load   load i_val (takes priority over counting)
//   i_val    load value in clock cycles
//   i_en     count down while high, stops at zero
//   o_done   high while the count is zero
module lcd_delay_counter #(
    parameter int W = 32,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    input  logic         i_en,
    output logic         o_done
);
    logic [W-1:0] r_cnt;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_cnt <= RST_VAL;
        else if (i_load) r_cnt <= i_val;
        else if (i_en && r_cnt != '0) r_cnt <= r_cnt - W'(1);
    end
    assign o_done = r_cnt == '0;
endmodule

// File: rtl/lcd_msg_sequencer.sv
// lcd_msg_sequencer: feeds an HD44780 byte writer with the init list, then 32-char messages on request
//   iClk       clock
//   iReset     synchronous active-low reset
//   iStart     message (re)write request, level sampled every cycle
//   iWrDone    writer's one-cycle byte-complete pulse
//   iChar      message memory data, valid one cycle after oCharAddr
//   oCharAddr  message memory address
//   oDato      byte to the writer
//   oRS        0 = command, 1 = character
//   oWrStart   one-cycle write request
//   oBusy      init, wait or transfer in progress
//   oReady     init complete
module lcd_msg_sequencer
    import lcd_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int POWERUP_US = 15000,
    parameter int CLEAR_US   = 2000,
    parameter int MSG_LEN    = 32
) (
    input  logic       iClk,
    input  logic       iReset,
    input  logic       iStart,
    input  logic       iWrDone,
    input  logic [7:0] iChar,
    output logic [4:0] oCharAddr,
    output logic [7:0] oDato,
    output logic       oRS,
    output logic       oWrStart,
    output logic       oBusy,
    output logic       oReady
);
    localparam int CYC_US  = CLK_HZ / 1000000;
    localparam int PWR_CYC = POWERUP_US * CYC_US;
    localparam int CLR_CYC = CLEAR_US * CYC_US;
    localparam logic [4:0] LAST_IDX = 5'(MSG_LEN - 1);
    localparam logic [4:0] HALF_IDX = 5'(MSG_LEN / 2 - 1);
    localparam logic [2:0] LAST_INIT = 3'(INIT_LEN - 1);

    state_t     r_state;
    logic [2:0] r_init_idx;
    logic [4:0] r_idx;
    logic [7:0] r_dato;
    logic       r_rs;
    logic       r_wr_start;
    logic       r_busy;
    logic       r_ready;
    logic       r_pending;
    logic       w_dly_done;
    logic       w_dly_load;
    logic       w_dly_en;

    // oDato still holds the command being written, so it identifies the clear completion
    assign w_dly_load = r_state == S_INIT_WAIT && iWrDone && r_dato == CMD_CLEAR;
    assign w_dly_en   = r_state == S_PWRUP || r_state == S_CLR_WAIT;

    lcd_delay_counter #(
        .W      (32),
        .RST_VAL(32'(PWR_CYC))
    ) u_delay (
        .i_clk  (iClk),
        .i_rst_n(iReset),
        .i_load (w_dly_load),
        .i_val  (32'(CLR_CYC)),
        .i_en   (w_dly_en),
        .o_done (w_dly_done)
    );

    // r_idx doubles as the memory address: it is presented well before FETCH2 samples iChar
    always_ff @(posedge iClk) begin
        if (!iReset) begin
            r_state    <= S_PWRUP;
            r_init_idx <= '0;
            r_idx      <= '0;
            r_dato     <= '0;
            r_rs       <= 1'b0;
            r_wr_start <= 1'b0;
            r_busy     <= 1'b1;
            r_ready    <= 1'b0;
            r_pending  <= 1'b0;
        end else begin
            r_wr_start <= 1'b0;
            if (iStart && r_state != S_IDLE) r_pending <= 1'b1;
            case (r_state)
                S_PWRUP: if (w_dly_done) r_state <= S_INIT_ISSUE;
                S_INIT_ISSUE: begin
                    r_dato     <= init_byte(r_init_idx);
                    r_rs       <= 1'b0;
                    r_wr_start <= 1'b1;
                    r_state    <= S_INIT_WAIT;
                end
                S_INIT_WAIT: if (iWrDone) begin
                    r_init_idx <= r_init_idx + 3'd1;
                    if (r_dato == CMD_CLEAR) r_state <= S_CLR_WAIT;
                    else if (r_init_idx == LAST_INIT) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else r_state <= S_INIT_ISSUE;
                end
                S_CLR_WAIT: if (w_dly_done) r_state <= S_INIT_ISSUE;
                // line-1 address goes out directly so oWrStart follows iStart by one cycle
                S_IDLE: if (iStart || r_pending) begin
                    r_pending  <= 1'b0;
                    r_busy     <= 1'b1;
                    r_dato     <= CMD_LINE1;
                    r_rs       <= 1'b0;
                    r_wr_start <= 1'b1;
                    r_state    <= S_ADDR_WAIT;
                end
                S_ADDR_ISSUE: begin
                    r_dato     <= CMD_LINE2;
                    r_rs       <= 1'b0;
                    r_wr_start <= 1'b1;
                    r_state    <= S_ADDR_WAIT;
                end
                S_ADDR_WAIT: if (iWrDone) r_state <= S_FETCH;
                S_FETCH: r_state <= S_FETCH2;
                S_FETCH2: begin
                    r_dato  <= iChar;
                    r_rs    <= 1'b1;
                    r_state <= S_CHAR_ISSUE;
                end
                S_CHAR_ISSUE: begin
                    r_wr_start <= 1'b1;
                    r_state    <= S_CHAR_WAIT;
                end
                S_CHAR_WAIT: if (iWrDone) begin
                    r_idx   <= r_idx + 5'd1;
                    r_busy  <= r_idx != LAST_IDX;
                    r_state <= r_idx == LAST_IDX ? S_IDLE : r_idx == HALF_IDX ? S_ADDR_ISSUE : S_FETCH;
                end
                default: r_state <= S_PWRUP;
            endcase
        end
    end

    assign oCharAddr = r_idx;
    assign oDato     = r_dato;
    assign oRS       = r_rs;
    assign oWrStart  = r_wr_start;
    assign oBusy     = r_busy;
    assign oReady    = r_ready;
endmodule

// File: tb/tb_lcd_msg_sequencer.sv
// tb_lcd_msg_sequencer: directed bench for the LCD init/message sequencer with a writer and ROM model
module tb_lcd_msg_sequencer;
    typedef struct packed {logic rs; logic [7:0] d;} exp_t;
    typedef struct {logic rs; logic [7:0] d; int cyc; int gap;} cap_t;

    logic clk = 0, rst_n = 0, start = 0, done_m = 0, done_f = 0, wr_en = 1;
    logic wr_done;
    logic [7:0] ch = 0;
    logic [4:0] addr;
    logic [7:0] dato;
    logic rs, wst, busy, ready;
    logic [7:0] rom [32];
    exp_t init_tab [7];
    exp_t msg_tab [34];
    cap_t caps [$];
    int cyc = 0, last_done = 0, wd_cnt = 0, ready_gap = -1, busy_gap = -1;
    int checks = 0, failures = 0;
    logic prev_ready = 0, prev_busy = 1;

    assign wr_done = done_m | done_f;

    lcd_msg_sequencer #(
        .CLK_HZ(1000000), .POWERUP_US(10), .CLEAR_US(5), .MSG_LEN(32)
    ) dut (
        .iClk(clk), .iReset(rst_n), .iStart(start), .iWrDone(wr_done), .iChar(ch),
        .oCharAddr(addr), .oDato(dato), .oRS(rs), .oWrStart(wst), .oBusy(busy), .oReady(ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        ch  <= rom[addr];
    end

    // monitor first, then the writer model (done 3 cycles after each start)
    always @(negedge clk) begin
        if (wst) caps.push_back('{rs, dato, cyc, cyc - last_done});
        if (ready && !prev_ready) ready_gap = cyc - last_done;
        if (!busy && prev_busy) busy_gap = cyc - last_done;
        prev_ready = ready;
        prev_busy  = busy;
        done_m = 1'b0;
        if (wd_cnt != 0) begin
            wd_cnt--;
            if (wd_cnt == 0) begin
                done_m = 1'b1;
                last_done = cyc;
            end
        end
        if (wst && wr_en) wd_cnt = 3;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic cap_t cap_at(input int i);
        cap_t c = '{1'b1, 8'hFF, -1000, -1000};
        if (i < caps.size()) c = caps[i];
        return c;
    endfunction

    task automatic check_seq(input string tag, input int base, input int n, input bit is_msg);
        for (int i = 0; i < n; i++) begin
            cap_t c = cap_at(base + i);
            exp_t e = is_msg ? msg_tab[i] : init_tab[i];
            check($sformatf("%s[%0d]", tag, i), {23'd0, c.rs, c.d}, {23'd0, e});
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_dato"}, dato, 0);
        check({tag, "_rs"}, rs, 0);
        check({tag, "_wst"}, wst, 0);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_ready"}, ready, 0);
        check({tag, "_addr"}, addr, 0);
    endtask

    task automatic wait_size(input string tag, input int n, input int bound);
        int k = 0;
        while (caps.size() < n && k < bound) begin
            tick();
            k++;
        end
        if (caps.size() < n) check({tag, "_timeout"}, caps.size(), n);
    endtask

    task automatic wait_xfer(input string tag, input int n);
        int k = 0;
        while (!(caps.size() >= n && !busy) && k < 3000) begin
            tick();
            k++;
        end
        check({tag, "_done_in_time"}, k < 3000, 1);
        repeat (20) tick();
    endtask

    initial begin
        int base, rel, s, bad;
        logic [23:0] snap;
        for (int i = 0; i < 32; i++) rom[i] = 8'h41 + 8'(i);
        init_tab = '{9'h038, 9'h038, 9'h038, 9'h038, 9'h00C, 9'h001, 9'h006};
        msg_tab[0]  = 9'h080;
        msg_tab[17] = 9'h0C0;
        for (int i = 0; i < 16; i++) begin
            msg_tab[1 + i]  = {1'b1, 8'h41 + 8'(i)};
            msg_tab[18 + i] = {1'b1, 8'h51 + 8'(i)};
        end

        // reset values
        repeat (3) tick();
        check_reset("rst");

        // power-up wait and init list
        base = caps.size();
        rel = cyc;
        rst_n = 1;
        bad = 0;
        s = 0;
        while (!ready && s < 1000) begin
            tick();
            s++;
            if (!ready && !busy) bad++;
        end
        check("init_in_time", s < 1000, 1);
        check("init_busy_low", bad, 0);
        check("pwrup_gap_ok", (cap_at(base).cyc - rel >= 10) && (cap_at(base).cyc - rel <= 13), 1);
        check("init_count", caps.size() - base, 7);
        check_seq("init", base, 7, 0);
        check("clear_gap_ok", cap_at(base + 6).gap >= 5, 1);
        check("ready_gap", ready_gap, 1);
        check("ready_busy", busy, 0);

        // stray iWrDone in IDLE
        repeat (3) tick();
        snap = {addr, dato, rs, wst, busy, ready, 5'd0};
        base = caps.size();
        done_f = 1; tick(); done_f = 0; tick();
        done_f = 1; tick(); done_f = 0;
        repeat (5) tick();
        check("idle_done_outputs", {8'd0, addr, dato, rs, wst, busy, ready, 5'd0}, {8'd0, snap});
        check("idle_done_nostart", caps.size() - base, 0);

        // single message
        base = caps.size();
        s = cyc;
        start = 1; tick(); start = 0;
        wait_xfer("msg", base + 34);
        check("msg_start_latency", cap_at(base).cyc - s, 1);
        check("msg_count", caps.size() - base, 34);
        check_seq("msg", base, 34, 1);
        check("msg_busy_gap", busy_gap, 1);
        check("msg_addr_end", addr, 0);

        // two requests mid-transfer collapse into one extra transfer
        base = caps.size();
        start = 1; tick(); start = 0;
        wait_size("pend_a", base + 6, 500);
        start = 1; tick(); start = 0;
        wait_size("pend_b", base + 11, 500);
        start = 1; tick(); start = 0;
        wait_xfer("pend", base + 68);
        check("pend_count", caps.size() - base, 68);
        check_seq("pend1", base, 34, 1);
        check_seq("pend2", base + 34, 34, 1);

        // reset after the 5th character, start held through re-init
        base = caps.size();
        start = 1; tick(); start = 0;
        wait_size("mrst", base + 6, 500);
        rst_n = 0;
        tick();
        check_reset("mrst");
        base = caps.size();
        rel = cyc;
        rst_n = 1;
        start = 1;
        wait_size("mrst_first", base + 1, 100);
        start = 0;
        check("mrst_pwrup_gap_ok", (cap_at(base).cyc - rel >= 10) && (cap_at(base).cyc - rel <= 13), 1);
        wait_xfer("mrst", base + 41);
        check("mrst_count", caps.size() - base, 41);
        check_seq("mrst_init", base, 7, 0);
        check_seq("mrst_msg", base + 7, 34, 1);
        check("mrst_ready_gap", ready_gap, 1);
        check("mrst_ready", ready, 1);

        // writer never completes
        wr_en = 0;
        base = caps.size();
        start = 1; tick(); start = 0;
        wait_size("stall", base + 1, 50);
        bad = 0;
        repeat (60) begin
            tick();
            if (dato !== 8'h80 || rs !== 1'b0 || wst !== 1'b0 || busy !== 1'b1) bad++;
        end
        check("stall_stable", bad, 0);
        check("stall_count", caps.size() - base, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
